// File: rtl/lif_neuron_scheduler.sv
// Time-multiplexed leaky integrate-and-fire scheduler: one update datapath sweeps NUM_NEURONS states per tick.
// Define LIF_EXT_TICK_EN to replace the internal prescaler with an external tick input (ext_tick_i).

module lif_neuron_update #(
    parameter int POT_W        = 8,
    parameter int REF_W        = 4,
    parameter int REFRAC_TICKS = 2
) (
    input  logic [POT_W-1:0] pot_i,
    input  logic [REF_W-1:0] ref_i,
    input  logic             stim_i,
    input  logic [3:0]       weight_i,
    input  logic [POT_W-1:0] threshold_i,
    input  logic [2:0]       leak_shift_i,
    output logic [POT_W-1:0] pot_o,
    output logic [REF_W-1:0] ref_o,
    output logic             fire_o
);
    logic [POT_W-1:0] leak;
    logic [POT_W:0]   sum;
    logic [POT_W-1:0] sat;

    always_comb begin
        leak   = (leak_shift_i != 3'd0) ? (pot_i >> leak_shift_i) : '0;
        // One extra bit so the weight add can saturate instead of wrapping.
        sum    = {1'b0, pot_i} - {1'b0, leak} + (stim_i ? {{(POT_W-3){1'b0}}, weight_i} : '0);
        sat    = sum[POT_W] ? '1 : sum[POT_W-1:0];
        pot_o  = sat;
        ref_o  = '0;
        fire_o = 1'b0;
        if (ref_i != '0) begin
            pot_o = '0;
            ref_o = ref_i - REF_W'(1);
        end else if ((threshold_i != '0) && (sat >= threshold_i)) begin
            pot_o  = '0;
            ref_o  = REF_W'(REFRAC_TICKS);
            fire_o = 1'b1;
        end
    end
endmodule

module lif_neuron_scheduler #(
    parameter int          NUM_NEURONS  = 4,
    parameter int          POT_W        = 8,
    parameter int unsigned MAX_COUNT    = 24'd10_000_000,
    parameter int          REFRAC_TICKS = 2,
    localparam int         SEL_W        = $clog2(NUM_NEURONS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
`ifdef LIF_EXT_TICK_EN
    input  logic                   ext_tick_i,
`endif
    input  logic [NUM_NEURONS-1:0] stim_i,
    input  logic [3:0]             weight_i,
    input  logic [POT_W-1:0]       threshold_i,
    input  logic [2:0]             leak_shift_i,
    input  logic [SEL_W-1:0]       sel_i,
    output logic                   tick_o,
    output logic                   busy_o,
    output logic [NUM_NEURONS-1:0] spike_o,
    output logic                   spike_valid_o,
    output logic [POT_W-1:0]       pot_o,
    output logic                   overrun_o
);
    localparam int REF_W = 4;

    typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_t;

    state_t                            state_q, state_d;
    logic [SEL_W-1:0]                  idx_q, idx_d;
    logic [NUM_NEURONS-1:0]            stim_q, stim_d;
    logic [NUM_NEURONS-1:0]            acc_q, acc_d;
    logic [NUM_NEURONS-1:0]            spike_q, spike_d;
    logic [3:0]                        weight_q, weight_d;
    logic [POT_W-1:0]                  thr_q, thr_d;
    logic [2:0]                        ls_q, ls_d;
    logic [NUM_NEURONS-1:0][POT_W-1:0] pot_q, pot_d;
    logic [NUM_NEURONS-1:0][REF_W-1:0] ref_q, ref_d;
    logic [POT_W-1:0]                  pot_out_q, pot_out_d;
    logic                              overrun_q, overrun_d;
    logic                              tick;
    logic [POT_W-1:0]                  upd_pot;
    logic [REF_W-1:0]                  upd_ref;
    logic                              upd_fire;

`ifdef LIF_EXT_TICK_EN
    assign tick = ena & ext_tick_i;
`else
    localparam int CNT_W = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = ena && (cnt_q == CNT_W'(MAX_COUNT - 1));
        cnt_d = cnt_q;
        if (ena) cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`endif

    lif_neuron_update #(
        .POT_W        (POT_W),
        .REF_W        (REF_W),
        .REFRAC_TICKS (REFRAC_TICKS)
    ) u_upd (
        .pot_i        (pot_q[idx_q]),
        .ref_i        (ref_q[idx_q]),
        .stim_i       (stim_q[idx_q]),
        .weight_i     (weight_q),
        .threshold_i  (thr_q),
        .leak_shift_i (ls_q),
        .pot_o        (upd_pot),
        .ref_o        (upd_ref),
        .fire_o       (upd_fire)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        stim_d    = stim_q;
        weight_d  = weight_q;
        thr_d     = thr_q;
        ls_d      = ls_q;
        acc_d     = acc_q;
        spike_d   = spike_q;
        pot_d     = pot_q;
        ref_d     = ref_q;
        overrun_d = overrun_q | (tick & (state_q != IDLE));
        case (state_q)
            IDLE: begin
                if (tick) begin
                    stim_d   = stim_i;
                    weight_d = weight_i;
                    thr_d    = threshold_i;
                    ls_d     = leak_shift_i;
                    idx_d    = '0;
                    acc_d    = '0;
                    state_d  = UPDATE;
                end
            end
            UPDATE: begin
                pot_d[idx_q] = upd_pot;
                ref_d[idx_q] = upd_ref;
                acc_d[idx_q] = upd_fire;
                // Publish on the last write so spike_o is already valid during DONE.
                if (idx_q == SEL_W'(NUM_NEURONS - 1)) begin
                    spike_d = acc_d;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + SEL_W'(1);
                end
            end
            DONE: begin
                acc_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Read through the write port so a value written at an edge is visible right after it.
        pot_out_d = '0;
        if (int'(sel_i) < NUM_NEURONS) pot_out_d = pot_d[sel_i];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            stim_q    <= '0;
            weight_q  <= '0;
            thr_q     <= '0;
            ls_q      <= '0;
            acc_q     <= '0;
            spike_q   <= '0;
            pot_q     <= '0;
            ref_q     <= '0;
            pot_out_q <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            stim_q    <= stim_d;
            weight_q  <= weight_d;
            thr_q     <= thr_d;
            ls_q      <= ls_d;
            acc_q     <= acc_d;
            spike_q   <= spike_d;
            pot_q     <= pot_d;
            ref_q     <= ref_d;
            pot_out_q <= pot_out_d;
            overrun_q <= overrun_d;
        end
    end

    assign tick_o        = tick;
    assign busy_o        = (state_q != IDLE);
    assign spike_valid_o = (state_q == DONE);
    assign spike_o       = spike_q;
    assign pot_o         = pot_out_q;
    assign overrun_o     = overrun_q;
endmodule

// File: tb/tb_lif_neuron_scheduler.sv
// Bench for lif_neuron_scheduler: sweep-level reference model compared every cycle against instance A,
// directed sequences with hand-computed values, and an overrun instance B with a short prescaler.
module tb_lif_neuron_scheduler;
    localparam int NN    = 4;
    localparam int PW    = 8;
    localparam int MAX_A = 8;
    localparam int MAX_B = 4;
    localparam int REFR  = 2;

    logic          clk = 1'b0;
    logic          rst_n, ena;
    logic [NN-1:0] stim;
    logic [3:0]    weight;
    logic [PW-1:0] thr;
    logic [2:0]    ls;
    logic [1:0]    sel;

    logic          tick_a, busy_a, valid_a, ovr_a;
    logic [NN-1:0] spike_a;
    logic [PW-1:0] pot_a;
    logic          tick_b, busy_b, valid_b, ovr_b;
    logic [NN-1:0] spike_b;
    logic [PW-1:0] pot_b;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;
    bit tog_en = 1'b0;

    always #5 clk = ~clk;

`ifdef LIF_EXT_TICK_EN
    logic ext_a = 1'b0, ext_b = 1'b0;
    int   tbcnt = 0;
    always @(posedge clk) begin
        #1;
        tbcnt++;
        ext_a = (tbcnt % MAX_A == 0);
        ext_b = (tbcnt % MAX_B == 0);
    end
`endif

    lif_neuron_scheduler #(.NUM_NEURONS(NN), .POT_W(PW), .MAX_COUNT(MAX_A), .REFRAC_TICKS(REFR)) dut_a (
        .clk(clk), .rst_n(rst_n), .ena(ena),
`ifdef LIF_EXT_TICK_EN
        .ext_tick_i(ext_a),
`endif
        .stim_i(stim), .weight_i(weight), .threshold_i(thr), .leak_shift_i(ls), .sel_i(sel),
        .tick_o(tick_a), .busy_o(busy_a), .spike_o(spike_a), .spike_valid_o(valid_a),
        .pot_o(pot_a), .overrun_o(ovr_a)
    );

    lif_neuron_scheduler #(.NUM_NEURONS(NN), .POT_W(PW), .MAX_COUNT(MAX_B), .REFRAC_TICKS(REFR)) dut_b (
        .clk(clk), .rst_n(rst_n), .ena(ena),
`ifdef LIF_EXT_TICK_EN
        .ext_tick_i(ext_b),
`endif
        .stim_i(stim), .weight_i(weight), .threshold_i(thr), .leak_shift_i(ls), .sel_i(sel),
        .tick_o(tick_b), .busy_o(busy_b), .spike_o(spike_b), .spike_valid_o(valid_b),
        .pot_o(pot_b), .overrun_o(ovr_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model. m_age: -1 idle, 0..NN-1 neuron being written, NN publish cycle.
    // The whole sweep outcome is computed at the tick from the snapshot; writes are then replayed.
    int            m_cnt, m_age, m_potout;
    int            m_pot[NN], m_ref[NN], n_pot[NN], n_ref[NN];
    logic [NN-1:0] n_spk, m_spike;
    bit            m_ovr;

    always @(posedge clk) begin
        bit tk;
        int v;
        if (!rst_n) begin
            m_cnt = 0; m_age = -1; m_potout = 0; m_spike = '0; m_ovr = 1'b0;
            for (int i = 0; i < NN; i++) begin m_pot[i] = 0; m_ref[i] = 0; end
        end else begin
`ifdef LIF_EXT_TICK_EN
            tk = ena && ext_a;
`else
            tk = ena && (m_cnt == MAX_A - 1);
            if (ena) m_cnt = (m_cnt == MAX_A - 1) ? 0 : m_cnt + 1;
`endif
            if (m_age >= 0 && m_age < NN) begin
                m_pot[m_age] = n_pot[m_age];
                m_ref[m_age] = n_ref[m_age];
                if (m_age == NN - 1) m_spike = n_spk;
            end
            if (tk && m_age >= 0) m_ovr = 1'b1;
            if (m_age == NN) m_age = -1;
            else if (m_age >= 0) m_age++;
            else if (tk) begin
                for (int i = 0; i < NN; i++) begin
                    n_spk[i] = 1'b0;
                    if (m_ref[i] > 0) begin
                        n_pot[i] = 0;
                        n_ref[i] = m_ref[i] - 1;
                    end else begin
                        v = m_pot[i] - ((ls != 0) ? (m_pot[i] >> ls) : 0) + (stim[i] ? int'(weight) : 0);
                        if (v > (1 << PW) - 1) v = (1 << PW) - 1;
                        if (thr != 0 && v >= int'(thr)) begin
                            n_spk[i] = 1'b1; n_pot[i] = 0; n_ref[i] = REFR;
                        end else begin
                            n_pot[i] = v; n_ref[i] = 0;
                        end
                    end
                end
                m_age = 0;
            end
            m_potout = m_pot[sel];
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
`ifdef LIF_EXT_TICK_EN
            chk("tick_o", tick_a, ena && ext_a);
`else
            chk("tick_o", tick_a, ena && (m_cnt == MAX_A - 1));
`endif
            chk("busy_o", busy_a, m_age >= 0);
            chk("spike_valid_o", valid_a, m_age == NN);
            chk("spike_o", spike_a, m_spike);
            chk("pot_o", pot_a, m_potout);
            chk("overrun_o", ovr_a, m_ovr);
        end
    end

    // Scrambles stim while a sweep runs; the idle value is what the snapshot must capture.
    always @(posedge clk) begin
        #1;
        if (tog_en) stim = busy_a ? NN'($urandom) : 4'b0001;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string nm, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (valid_a) begin ok = 1'b1; break; end
        end
        #1;
        if (!ok) begin
            n_chk++; n_fail++;
            $display("FAIL %s: spike_valid_o timeout, got 0 expected 1", nm);
        end
    endtask

    initial begin
        bit ok;
        int k;
        int exp2_pot[8];
        exp2_pot = '{10, 20, 29, 38, 0, 0, 0, 10};

        rst_n = 1'b0; ena = 1'b0; stim = '0; weight = '0; thr = '0; ls = '0; sel = '0;
        step;
        chk_en = 1'b1;
        step;
        rst_n = 1'b1; ena = 1'b1;
        @(negedge clk); #1;
        chk("rst_busy", busy_a, 0);
        chk("rst_valid", valid_a, 0);
        chk("rst_spike", spike_a, 0);
        chk("rst_pot", pot_a, 0);
        chk("rst_ovr", ovr_a, 0);
        chk("rst_b_busy", busy_b, 0);
`ifndef LIF_EXT_TICK_EN
        chk("rst_tick", tick_a, 0);
        k = 0;
        while (!tick_a && k < 30) begin @(negedge clk); k++; end
        chk("first_tick_delay", k, 7);
        k = 0;
        do begin @(negedge clk); k++; end while (!tick_a && k < 30);
        chk("tick_period", k, 8);
`endif

        // Leak/fire/refractory sequence with stim scrambled during every sweep.
        step;
        rst_n = 1'b0; stim = 4'b0001; weight = 4'd10; ls = 3'd4; thr = 8'd40; sel = 2'd0;
        step;
        rst_n = 1'b1; tog_en = 1'b1;
        for (int s = 0; s < 8; s++) begin
            wait_valid("seq2_valid", ok);
            if (ok) begin
                chk("seq2_pot", pot_a, exp2_pot[s]);
                chk("seq2_spike", spike_a, (s == 4) ? 1 : 0);
            end
        end
        tog_en = 1'b0;

        // Saturation with firing disabled.
        step;
        rst_n = 1'b0; stim = 4'hF; weight = 4'd15; ls = 3'd0; thr = 8'd0; sel = 2'd3;
        step;
        rst_n = 1'b1;
        for (int s = 1; s <= 18; s++) begin
            wait_valid("sat_valid", ok);
            if (ok && s == 1)  chk("sat_pot_1", pot_a, 15);
            if (ok && s == 10) chk("sat_pot_10", pot_a, 150);
            if (ok && s == 17) chk("sat_pot_17", pot_a, 255);
            if (ok && s == 18) begin
                chk("sat_pot_18", pot_a, 255);
                chk("sat_spike", spike_a, 0);
            end
        end

        // Overrun on the short-period instance, then reset in the middle of a sweep.
        step;
        rst_n = 1'b0;
        step;
        rst_n = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!tick_b && k < 20);
        chk("b_tick1", tick_b, 1);
        chk("b_ovr_before", ovr_b, 0);
        k = 0;
        do begin @(negedge clk); k++; end while (!tick_b && k < 20);
        chk("b_tick2_while_busy", busy_b, 1);
        @(negedge clk);
        chk("b_ovr_after", ovr_b, 1);
`ifndef LIF_EXT_TICK_EN
        k = 0;
        for (int i = 0; i < 24; i++) begin @(negedge clk); if (valid_b) k++; end
        chk("b_sweeps_complete", k, 3);
`endif
        k = 0;
        do begin @(negedge clk); k++; end while (!(busy_b && !valid_b) && k < 20);
        chk("b_busy_found", busy_b, 1);
        chk("b_pot_nonzero", pot_b != 0, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        step;
        rst_n = 1'b1;
        @(negedge clk);
        chk("b_rst_busy", busy_b, 0);
        chk("b_rst_ovr", ovr_b, 0);
        chk("b_rst_pot", pot_b, 0);
        chk("b_rst_valid", valid_b, 0);

        // Randomised traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            step;
            rst_n  = ($urandom_range(0, 399) != 0);
            ena    = ($urandom_range(0, 9) != 0);
            stim   = NN'($urandom);
            weight = 4'($urandom);
            thr    = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 70));
            ls     = 3'($urandom_range(0, 7));
            sel    = 2'($urandom_range(0, 3));
        end
        step;
        step;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
